// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int MUL_W    = 16;
  localparam int MUL_ITER = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_16.sv
// 16-bit ripple-carry adder; the combinational datapath under mul_16_seq.
module rca_16
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] x,
  input  logic [MUL_W-1:0] y,
  input  logic             c_in,
  output logic [MUL_W-1:0] sum,
  output logic             c_out
);

  logic carry;

  always_comb begin
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < MUL_W; i++) begin
      sum[i] = x[i] ^ y[i] ^ carry;
      carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/mul_16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one adder pass per clock.
// Optional MUL_EARLY_EXIT_EN: zero operands skip straight from IDLE to DONE.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one partial-product add and right shift per cycle, 16 cycles
// DONE  | product valid, done pulses for one cycle
module mul_16_seq
  import mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MUL_W-1:0]   a,
  input  logic [MUL_W-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*MUL_W-1:0] product
);

  state_t           state, state_nxt;
  logic [MUL_W-1:0] mcand, mplr, acc;
  logic [3:0]       cnt;
  logic [MUL_W-1:0] add_y, sum;
  logic             c_out;
  logic [MUL_W-1:0] acc_nxt, mplr_nxt;
  logic             last_iter, zero_op;

`ifdef MUL_EARLY_EXIT_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The shifted-in top bit of the accumulator is always zero, so only 16 bits are kept.
  assign add_y     = mplr[0] ? mcand : '0;
  assign acc_nxt   = {c_out, sum[MUL_W-1:1]};
  assign mplr_nxt  = {sum[0], mplr[MUL_W-1:1]};
  assign last_iter = (cnt == 4'(MUL_ITER - 1));

  rca_16 u_add (
    .x     (acc),
    .y     (add_y),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = zero_op ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand <= a;
          mplr  <= b;
          acc   <= '0;
          cnt   <= '0;
          if (zero_op) product <= '0;
        end
        RUN: begin
          acc  <= acc_nxt;
          mplr <= mplr_nxt;
          cnt  <= cnt + 4'd1;
          if (last_iter) product <= {acc_nxt, mplr_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_16_seq.sv
// Self-checking bench for mul_16_seq: vector table, start-held, mid-run reset, random pairs.
module tb_mul_16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done;
  logic [31:0] product;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation and check latency, busy width, product and done-pulse width.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [31:0] exp,
                        input string name);
    int  i, nb, exp_neg, exp_busy;
    bit  seen;
    bit  zero;
    zero     = (ta == 16'd0) || (tb == 16'd0);
    exp_neg  = (EARLY && zero) ? 1 : 17;
    exp_busy = (EARLY && zero) ? 0 : 16;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    i = 0; nb = 0; seen = 1'b0;
    while (!seen && i < 40) begin
      @(negedge clk);
      i++;
      if (done) seen = 1'b1;
      else begin
        if (busy) nb++;
        a = 16'($urandom); b = 16'($urandom);
      end
    end
    chk({name, " latency"}, 32'(i), 32'(exp_neg));
    chk({name, " busy_cycles"}, 32'(nb), 32'(exp_busy));
    chk({name, " product"}, product, exp);
    chk({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({name, " done_pulse_width"}, {31'd0, done}, 32'd0);
    chk({name, " product_held"}, product, exp);
  endtask

  logic [15:0] ha[64];
  logic [15:0] hb[64];
  int          done_cyc[$];
  logic [31:0] done_prod[$];
  int          acc_edge[$];

  initial begin
    vecs[0] = '{16'd3,     16'd5,     32'h0000_000F, "3x5"};
    vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE_0001, "max_x_max"};
    vecs[2] = '{16'h1234,  16'h0000,  32'h0000_0000, "a_x_zero"};
    vecs[3] = '{16'h0000,  16'hBEEF,  32'h0000_0000, "zero_x_b"};
    vecs[4] = '{16'hFFFF,  16'h0001,  32'h0000_FFFF, "max_x_one"};
    vecs[5] = '{16'h8000,  16'h8000,  32'h4000_0000, "msb_x_msb"};
    vecs[6] = '{16'h00FF,  16'h0101,  32'h0000_FFFF, "ff_x_0101"};
    vecs[7] = '{16'hABCD,  16'h0002,  32'h0001_579A, "abcd_x_2"};
    vecs[8] = '{16'h0001,  16'h0001,  32'h0000_0001, "one_x_one"};

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_product", product, 32'd0);

    for (int k = 0; k < 9; k++) run_op(vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].name);

    // start held high with operands changing every cycle
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(c);
        done_prod.push_back(product);
      end
      start = (c < 36);
      a = 16'($urandom_range(1, 65535));
      b = 16'($urandom_range(1, 65535));
      ha[c] = a; hb[c] = b;
    end
    start = 1'b0;
    begin
      int next_ok;
      next_ok = 0;
      for (int e = 0; e < 36; e++)
        if (e >= next_ok) begin
          acc_edge.push_back(e);
          next_ok = e + 18;
        end
    end
    chk("held_start_done_count", 32'(done_cyc.size()), 32'(acc_edge.size()));
    for (int k = 0; k < acc_edge.size() && k < done_cyc.size(); k++) begin
      chk($sformatf("held_start_done_time_%0d", k), 32'(done_cyc[k]), 32'(acc_edge[k] + 17));
      chk($sformatf("held_start_product_%0d", k), done_prod[k],
          32'(ha[acc_edge[k]]) * 32'(hb[acc_edge[k]]));
    end

    // reset in the middle of a run
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int nd;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk("midrun_rst_no_done", 32'(nd), 32'd0);
    end
    run_op(16'h00FF, 16'h0101, 32'h0000_FFFF, "after_rst");

    for (int k = 0; k < 200; k++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 50 == 7) rb = 16'd0;
      run_op(ra, rb, 32'(ra) * 32'(rb), $sformatf("rand_%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
